axicb_rd_order_ctrl: RTL and testbench
======================================

# axicb_rd_order_ctrl

Read-ordering controller placed on the AR path between a master agent and its slave read switch. It tracks outstanding read transactions per AXI ID and stalls any new AR whose ID is already outstanding toward a different slave, or toward the decode-error completer. This keeps same-ID read completions in issue order across slaves. It observes the R channel to retire transactions and never modifies the address or data payload.

## Interface
Parameters:
- AXI_ID_W, 8, ID width in bits
- SLV_NB, 4, number of slaves; width of the one-hot target vector
- TRACK_NB, 4, number of tracking entries, i.e. distinct IDs that can be outstanding at once
- CNT_W, 4, per-entry outstanding counter width; maximum outstanding per entry is 2^CNT_W-1

Ports:
- aclk in 1 clock
- srst in 1 synchronous active-high reset
- i_arvalid in 1 AR valid from master
- i_arready out 1 AR ready to master
- i_arid in AXI_ID_W ARID of the current request
- i_artgt in SLV_NB one-hot decoded target; all-zero means misrouted (DECERR destination)
- o_arvalid out 1 AR valid to slave switch
- o_arready in 1 AR ready from slave switch
- i_rvalid in 1 R valid, monitored
- i_rready in 1 R ready, monitored
- i_rlast in 1 R last, monitored
- i_rid in AXI_ID_W RID, monitored
- o_busy out 1 at least one entry valid
- o_full out 1 all TRACK_NB entries valid
- o_err out 1 one-cycle pulse on an unmatched R-last; see Configuration

## Operation
- Each entry holds: valid, id[AXI_ID_W], tgt[SLV_NB], cnt[CNT_W].
- hit = a valid entry exists with id==i_arid. At most one entry can hit.
- allow is combinational from registered state and the AR inputs only; it has no dependency on o_arready.
  - Hit, tgt==i_artgt, cnt<max: allow=1.
  - Hit, tgt!=i_artgt: allow=0 (ordering stall).
  - Hit, cnt==max: allow=0 (saturation stall).
  - No hit, a free entry exists: allow=1.
  - No hit, table full: allow=0.
- o_arvalid = i_arvalid & allow & !srst.
- i_arready = o_arready & allow & !srst.
- AR handshake (o_arvalid & o_arready):
  - On hit, cnt+1.
  - Otherwise, allocate the lowest-index free entry with id=i_arid, tgt=i_artgt, cnt=1.
- R retire (i_rvalid & i_rready & i_rlast): the entry with id==i_rid decrements cnt. When cnt reaches 0, valid clears and the entry is free on the next cycle.
- AR handshake and R retire on the same entry in the same cycle: cnt unchanged, entry stays valid, tgt unchanged.
- AR handshake allocates while R retire frees a different entry in the same cycle: both take effect. The entry freed this cycle is not eligible for allocation until the next cycle.
- R retire with no matching valid entry: table unchanged; o_err behaviour per Configuration.
- R beats without i_rlast are ignored.

## Timing
- Reset values (srst high at a clock edge): all entries invalid, cnt=0, o_busy=0, o_full=0, o_err=0.
- While srst is high, o_arvalid=0 and i_arready=0 combinationally.
- srst asserted mid-transaction drops all tracking. Completions in flight are then unmatched; the surrounding switch is reset in the same cycle.
- AR path: zero-cycle latency, combinational pass-through when allow=1.
- Table update is visible at the next edge. An AR in the cycle after a handshake sees the updated cnt/valid.
- A stalled request becomes allowed in the cycle after the blocking entry frees, with no extra bubble.
- o_busy and o_full are registered, derived from next-state entry valids.
- o_err is registered, one cycle after the offending R-last handshake.

## Configuration
- AXICB_RD_ORDER_CHECK_EN
  - Defined: an R-last handshake with no matching valid entry raises o_err for exactly one cycle.
  - Undefined: o_err is tied to 0 and the matching-miss detection logic is not built.
- Tracking behaviour is identical in both builds.

## Test plan
- Reset then idle: o_busy=0, o_full=0, o_err=0. AR id=3 tgt=4'b0001 with o_arready=1 -> handshake the same cycle; o_busy=1 next cycle.
- Same ID, same slave: 3 ARs id=5 tgt=4'b0010 -> all pass, cnt=3. Three R-last id=5 -> entry freed, o_busy=0.
- Ordering stall: id=7 outstanding to tgt=4'b0001, new AR id=7 tgt=4'b0100 -> o_arvalid=0, i_arready=0 until R-last id=7. Handshake the cycle after the entry frees.
- Full table, TRACK_NB=4: IDs 1-4 outstanding -> o_full=1. AR id=9 stalls; AR id=2 to its same target passes.
- Simultaneous events: cnt=1 for id=6, AR id=6 same tgt and R-last id=6 in the same cycle -> cnt stays 1, entry remains valid.
- With AXICB_RD_ORDER_CHECK_EN defined: R-last id=0xAA with an empty table -> o_err=1 for one cycle. Without the macro -> o_err stays 0.

Source files
------------

// File: rtl/axicb_rd_order_ctrl.sv
// AR-path read-ordering controller: stalls same-ID reads toward a different slave until retired.
// Optional AXICB_RD_ORDER_CHECK_EN builds the unmatched R-last detector driving o_err.
module axicb_rd_order_ctrl #(
    parameter int AXI_ID_W = 8,
    parameter int SLV_NB   = 4,
    parameter int TRACK_NB = 4,
    parameter int CNT_W    = 4
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic                i_arvalid,
    output logic                i_arready,
    input  logic [AXI_ID_W-1:0] i_arid,
    input  logic [SLV_NB-1:0]   i_artgt,
    output logic                o_arvalid,
    input  logic                o_arready,
    input  logic                i_rvalid,
    input  logic                i_rready,
    input  logic                i_rlast,
    input  logic [AXI_ID_W-1:0] i_rid,
    output logic                o_busy,
    output logic                o_full,
    output logic                o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [TRACK_NB-1:0] ent_vld, ent_vld_nxt;
    logic [AXI_ID_W-1:0] ent_id     [TRACK_NB];
    logic [AXI_ID_W-1:0] ent_id_nxt [TRACK_NB];
    logic [SLV_NB-1:0]   ent_tgt    [TRACK_NB];
    logic [SLV_NB-1:0]   ent_tgt_nxt[TRACK_NB];
    logic [CNT_W-1:0]    ent_cnt    [TRACK_NB];
    logic [CNT_W-1:0]    ent_cnt_nxt[TRACK_NB];

    logic [TRACK_NB-1:0] hit_vec, rmatch_vec, free_sel;
    logic                free_found, hit, allow, ar_hs, r_ret;
    logic [SLV_NB-1:0]   hit_tgt;
    logic [CNT_W-1:0]    hit_cnt;

    always_comb begin
        hit_vec    = '0;
        rmatch_vec = '0;
        free_sel   = '0;
        free_found = 1'b0;
        hit_tgt    = '0;
        hit_cnt    = '0;
        for (int i = 0; i < TRACK_NB; i++) begin
            hit_vec[i]    = ent_vld[i] && (ent_id[i] == i_arid);
            rmatch_vec[i] = ent_vld[i] && (ent_id[i] == i_rid);
            if (hit_vec[i]) begin
                hit_tgt = hit_tgt | ent_tgt[i];
                hit_cnt = hit_cnt | ent_cnt[i];
            end
            // Lowest-index free slot, judged on current valids so a slot freed this cycle is skipped.
            if (!ent_vld[i] && !free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    assign hit   = |hit_vec;
    assign allow = hit ? ((hit_tgt == i_artgt) && (hit_cnt != CNT_MAX)) : free_found;

    assign o_arvalid = i_arvalid & allow & ~srst;
    assign i_arready = o_arready & allow & ~srst;

    assign ar_hs = o_arvalid & o_arready;
    assign r_ret = i_rvalid & i_rready & i_rlast;

    always_comb begin
        ent_vld_nxt = ent_vld;
        for (int i = 0; i < TRACK_NB; i++) begin
            ent_id_nxt[i]  = ent_id[i];
            ent_tgt_nxt[i] = ent_tgt[i];
            ent_cnt_nxt[i] = ent_cnt[i];
            if (ar_hs && !hit && free_sel[i]) begin
                ent_vld_nxt[i] = 1'b1;
                ent_id_nxt[i]  = i_arid;
                ent_tgt_nxt[i] = i_artgt;
                ent_cnt_nxt[i] = CNT_ONE;
            end else if (ar_hs && hit_vec[i] && r_ret && rmatch_vec[i]) begin
                ent_cnt_nxt[i] = ent_cnt[i];
            end else if (ar_hs && hit_vec[i]) begin
                ent_cnt_nxt[i] = ent_cnt[i] + CNT_ONE;
            end else if (r_ret && rmatch_vec[i]) begin
                ent_cnt_nxt[i] = ent_cnt[i] - CNT_ONE;
                if (ent_cnt[i] == CNT_ONE) begin
                    ent_vld_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            ent_vld <= '0;
            o_busy  <= 1'b0;
            o_full  <= 1'b0;
            for (int i = 0; i < TRACK_NB; i++) begin
                ent_id[i]  <= '0;
                ent_tgt[i] <= '0;
                ent_cnt[i] <= '0;
            end
        end else begin
            ent_vld <= ent_vld_nxt;
            o_busy  <= |ent_vld_nxt;
            o_full  <= &ent_vld_nxt;
            for (int i = 0; i < TRACK_NB; i++) begin
                ent_id[i]  <= ent_id_nxt[i];
                ent_tgt[i] <= ent_tgt_nxt[i];
                ent_cnt[i] <= ent_cnt_nxt[i];
            end
        end
    end

`ifdef AXICB_RD_ORDER_CHECK_EN
    logic err_q;

    always_ff @(posedge aclk) begin
        if (srst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= r_ret && !(|rmatch_vec);
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_rd_order_ctrl.sv
// Scoreboard bench for axicb_rd_order_ctrl: expected AR handshakes queued by stimulus, checked by a monitor.
module tb_axicb_rd_order_ctrl;

    logic       aclk = 1'b0;
    logic       srst;
    logic       i_arvalid, i_arready, o_arvalid, o_arready;
    logic [7:0] i_arid, i_rid;
    logic [3:0] i_artgt;
    logic       i_rvalid, i_rready, i_rlast;
    logic       o_busy, o_full, o_err;

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q[$];

    axicb_rd_order_ctrl #(.AXI_ID_W(8), .SLV_NB(4), .TRACK_NB(4), .CNT_W(4)) dut (
        .aclk(aclk), .srst(srst),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arid(i_arid), .i_artgt(i_artgt),
        .o_arvalid(o_arvalid), .o_arready(o_arready),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rid(i_rid),
        .o_busy(o_busy), .o_full(o_full), .o_err(o_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every AR handshake must match the next expected request in issue order.
    always @(negedge aclk) begin
        if (!srst && o_arvalid && o_arready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ar_hs", {20'd0, i_arid, i_artgt}, 32'hFFFF_FFFF);
            end else begin
                chk("ar_hs", {20'd0, i_arid, i_artgt}, {20'd0, exp_q.pop_front()});
                chk("ar_hs_ready", {31'd0, i_arready}, 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr();
        i_arvalid = 1'b0; i_arid = '0; i_artgt = '0; o_arready = 1'b1;
        i_rvalid = 1'b0; i_rready = 1'b0; i_rlast = 1'b0; i_rid = '0;
    endtask

    task automatic set_ar(input logic [7:0] id, input logic [3:0] tgt, input bit pass);
        i_arvalid = 1'b1; i_arid = id; i_artgt = tgt; o_arready = 1'b1;
        if (pass) exp_q.push_back({id, tgt});
        #1;
        chk($sformatf("arvalid_id%0h", id), {31'd0, o_arvalid}, {31'd0, pass});
        chk($sformatf("arready_id%0h", id), {31'd0, i_arready}, {31'd0, pass});
    endtask

    task automatic set_r(input logic [7:0] id);
        i_rvalid = 1'b1; i_rready = 1'b1; i_rlast = 1'b1; i_rid = id;
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [3:0] tgt);
        set_ar(id, tgt, 1'b1);
        cyc();
        clr();
    endtask

    task automatic do_r(input logic [7:0] id);
        set_r(id);
        cyc();
        clr();
    endtask

    logic exp_err;

    initial begin
`ifdef AXICB_RD_ORDER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clr();
        srst = 1'b1;
        i_arvalid = 1'b1; i_arid = 8'h3; i_artgt = 4'b0001;
        cyc(); cyc();
        chk("rst_arvalid", {31'd0, o_arvalid}, 32'd0);
        chk("rst_arready", {31'd0, i_arready}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        clr();
        srst = 1'b0;
        cyc();
        chk("idle_busy", {31'd0, o_busy}, 32'd0);

        // first request passes combinationally, busy one cycle later
        do_ar(8'h3, 4'b0001);
        chk("busy_after_ar", {31'd0, o_busy}, 32'd1);
        do_r(8'h3);
        chk("busy_after_r3", {31'd0, o_busy}, 32'd0);

        // same id, same slave, three deep
        for (int k = 0; k < 3; k++) do_ar(8'h5, 4'b0010);
        do_r(8'h5); do_r(8'h5);
        chk("busy_id5_1left", {31'd0, o_busy}, 32'd1);
        do_r(8'h5);
        chk("busy_id5_done", {31'd0, o_busy}, 32'd0);

        // ordering stall until the blocking entry retires, no bubble afterwards
        do_ar(8'h7, 4'b0001);
        set_ar(8'h7, 4'b0100, 1'b0);
        cyc();
        set_ar(8'h7, 4'b0100, 1'b0);
        set_r(8'h7);
        cyc();
        i_rvalid = 1'b0; i_rready = 1'b0; i_rlast = 1'b0;
        set_ar(8'h7, 4'b0100, 1'b1);
        cyc();
        clr();
        do_r(8'h7);
        chk("busy_id7_done", {31'd0, o_busy}, 32'd0);

        // full table: new id stalls, hit on an existing id still passes
        do_ar(8'h1, 4'b0001);
        do_ar(8'h2, 4'b0010);
        do_ar(8'h3, 4'b0100);
        chk("not_full_3", {31'd0, o_full}, 32'd0);
        do_ar(8'h4, 4'b1000);
        chk("full_4", {31'd0, o_full}, 32'd1);
        set_ar(8'h9, 4'b0001, 1'b0);
        cyc();
        clr();
        do_ar(8'h2, 4'b0010);
        do_r(8'h1);
        chk("not_full_after_r1", {31'd0, o_full}, 32'd0);
        do_r(8'h2); do_r(8'h3); do_r(8'h4);
        chk("busy_id2_left", {31'd0, o_busy}, 32'd1);
        do_r(8'h2);
        chk("busy_full_done", {31'd0, o_busy}, 32'd0);

        // simultaneous AR hit and retire keeps cnt at 1
        do_ar(8'h6, 4'b0001);
        set_r(8'h6);
        set_ar(8'h6, 4'b0001, 1'b1);
        cyc();
        clr();
        chk("simul_busy", {31'd0, o_busy}, 32'd1);
        do_r(8'h6);
        chk("simul_freed", {31'd0, o_busy}, 32'd0);

        // counter saturation at 15
        for (int k = 0; k < 15; k++) do_ar(8'h10, 4'b0100);
        set_ar(8'h10, 4'b0100, 1'b0);
        cyc();
        clr();
        for (int k = 0; k < 14; k++) do_r(8'h10);
        chk("sat_busy", {31'd0, o_busy}, 32'd1);
        do_r(8'h10);
        chk("sat_done", {31'd0, o_busy}, 32'd0);

        // unmatched R-last
        do_r(8'hAA);
        chk("err_pulse", {31'd0, o_err}, {31'd0, exp_err});
        chk("err_busy", {31'd0, o_busy}, 32'd0);
        cyc();
        chk("err_clear", {31'd0, o_err}, 32'd0);

        cyc();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
